tdm_demux_4: RTL and testbench



---
 rtl/tdm_demux_4.sv | 121 ++++++++++++
 tb/tb_tdm_demux_4.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4.sv
// tdm_demux_4 -- receive side of a 4-slot TDM link.
//
// Recovers slot position from a sync flag carried on slot 0. Slots 0..2 are
// held privately and published together with slot 3, so d0..d3 always come
// from a single complete frame.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   en          slot strobe; din/sync are sampled only when en=1
//   sync        frame marker, asserted with the slot-0 sample
//   din         current slot sample (W bits)
//   d0..d3      channel samples of the last complete frame
//   frame_valid one-cycle pulse, d0..d3 were just updated
//   locked      high while aligned to the frame
//   sel         slot index expected on the next en sample
//   sync_err    one-cycle pulse on a framing violation
module tdm_demux_4 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         sync,
    input  logic [W-1:0] din,
    output logic [W-1:0] d0,
    output logic [W-1:0] d1,
    output logic [W-1:0] d2,
    output logic [W-1:0] d3,
    output logic         frame_valid,
    output logic         locked,
    output logic [1:0]   sel,
    output logic         sync_err
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [2:0][W-1:0]   h_q, h_d;      // slots 0..2 of the frame in progress
    logic [3:0][W-1:0]   d_q, d_d;      // published frame
    logic                frame_valid_q, frame_valid_d;
    logic                sync_err_q, sync_err_d;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        h_d           = h_q;
        d_d           = d_q;
        // Both flags are single-cycle pulses; they only rise on an en sample.
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (en) begin
            if (state_q == HUNT) begin
                if (sync) begin
                    h_d[0]  = din;
                    sel_d   = 2'd1;
                    state_d = LOCKED;
                end
            end else if (sync) begin
                // A sync anywhere but slot 0 means we lost alignment: drop the
                // partial frame and restart on this sample.
                sync_err_d = (sel_q != 2'd0);
                h_d[0]     = din;
                sel_d      = 2'd1;
            end else begin
                unique case (sel_q)
                    2'd0: begin
                        // Missing sync: give up lock, keep published frame.
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        sel_d      = 2'd0;
                    end
                    2'd1: begin
                        h_d[1] = din;
                        sel_d  = 2'd2;
                    end
                    2'd2: begin
                        h_d[2] = din;
                        sel_d  = 2'd3;
                    end
                    2'd3: begin
                        d_d           = {din, h_q[2], h_q[1], h_q[0]};
                        frame_valid_d = 1'b1;
                        sel_d         = 2'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= HUNT;
            sel_q         <= 2'd0;
            h_q           <= '0;
            d_q           <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            h_q           <= h_d;
            d_q           <= d_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign d0          = d_q[0];
    assign d1          = d_q[1];
    assign d2          = d_q[2];
    assign d3          = d_q[3];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == LOCKED);
    assign sel         = sel_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// tb_tdm_demux_4 -- self-checking bench for tdm_demux_4.
//
// The reference model keeps the partial frame as a queue of received samples:
// its length is the expected slot index, and four entries make a frame.
module tb_tdm_demux_4;

    localparam int W  = 4;
    localparam int VW = 4 * W + 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] d0, d1, d2, d3;
    logic         frame_valid, locked, sync_err;
    logic [1:0]   sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdm_demux_4 #(.W(W)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .sync(sync), .din(din),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .frame_valid(frame_valid), .locked(locked), .sel(sel),
        .sync_err(sync_err)
    );

    // ---------------- reference model ----------------
    logic         m_locked;
    logic [W-1:0] m_part[$];
    logic [W-1:0] m_d[4];
    logic         m_fv, m_se;

    task automatic model_reset();
        m_locked = 1'b0;
        m_part.delete();
        for (int i = 0; i < 4; i++) m_d[i] = '0;
        m_fv = 1'b0;
        m_se = 1'b0;
    endtask

    task automatic model_apply(input logic e, input logic s, input logic [W-1:0] x);
        m_fv = 1'b0;
        m_se = 1'b0;
        if (e) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1'b1;
                    m_part.delete();
                    m_part.push_back(x);
                end
            end else if (s) begin
                if (m_part.size() != 0) m_se = 1'b1;
                m_part.delete();
                m_part.push_back(x);
            end else if (m_part.size() == 0) begin
                m_se     = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_part.push_back(x);
                if (m_part.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_d[i] = m_part[i];
                    m_fv = 1'b1;
                    m_part.delete();
                end
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [1:0] s2;
        s2 = 2'(m_part.size());
        return {m_d[0], m_d[1], m_d[2], m_d[3], m_fv, m_locked, s2, m_se};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {d0, d1, d2, d3, frame_valid, locked, sel, sync_err};
    endfunction

    // Drive one clock edge; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic e, input logic s, input logic [W-1:0] x);
        en = e; sync = s; din = x;
        @(posedge clk);
        model_apply(e, s, x);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en = 1'b0; sync = 1'b0; din = '0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", obs_vec());
        end
        do_reset();
    endtask

    task automatic test_basic_frame();
        logic [W-1:0] v[4] = '{1, 0, 1, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, v[i]);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic_slot%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({d0, d1, d2, d3, frame_valid, locked, sel} !== {W'(1), W'(0), W'(1), W'(1), 1'b1, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL basic_frame: got d=%h %h %h %h fv=%b lk=%b sel=%0d want 1 0 1 1 fv=1 lk=1 sel=0",
                     d0, d1, d2, d3, frame_valid, locked, sel);
        end
        step(1'b1, 1'b0, '0);  // missing sync also drops fv
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_fv_pulse: got %b want 0", frame_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i % 4) == 0, v[i]);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_en1_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            step(1'b0, 1'b1, 4'hf);  // ignored idle cycle
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_en0_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({d0, d1, d2, d3} !== {W'(1), W'(1), W'(1), W'(0)}) begin
            n_fail++;
            $display("FAIL b2b_second_frame: got %h %h %h %h want 1 1 1 0", d0, d1, d2, d3);
        end
    endtask

    task automatic test_missing_sync();
        logic [W-1:0] v[4] = '{4'h3, 4'h5, 4'h7, 4'h9};
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, v[i]);
        step(1'b1, 1'b0, 4'hc);
        n_checks++;
        if ({sync_err, locked, frame_valid, d0, d1, d2, d3} !==
            {1'b1, 1'b0, 1'b0, 4'h3, 4'h5, 4'h7, 4'h9}) begin
            n_fail++;
            $display("FAIL missing_sync: got se=%b lk=%b fv=%b d=%h%h%h%h want se=1 lk=0 fv=0 d=3579",
                     sync_err, locked, frame_valid, d0, d1, d2, d3);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, 4'(8 + i));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL relock_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_early_sync();
        do_reset();
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b1, 4'ha);   // sync at sel=2
        n_checks++;
        if ({sync_err, frame_valid, sel, locked} !== {1'b1, 1'b0, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL early_sync: got se=%b fv=%b sel=%0d lk=%b want se=1 fv=0 sel=1 lk=1",
                     sync_err, frame_valid, sel, locked);
        end
        step(1'b1, 1'b0, 4'hb);
        step(1'b1, 1'b0, 4'hc);
        step(1'b1, 1'b0, 4'hd);
        n_checks++;
        if ({frame_valid, sync_err, d0, d1, d2, d3} !== {1'b1, 1'b0, 4'ha, 4'hb, 4'hc, 4'hd}) begin
            n_fail++;
            $display("FAIL early_resync_frame: got fv=%b se=%b d=%h%h%h%h want fv=1 se=0 d=abcd",
                     frame_valid, sync_err, d0, d1, d2, d3);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 4'(i + 4));
        step(1'b1, 1'b1, 4'h6);
        step(1'b1, 1'b0, 4'h7);    // sel=2 now
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h want 0", obs_vec());
        end
        model_reset();
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 4'(i));
            n_checks++;
            if (obs_vec() !== exp_vec() || frame_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_hunt_noise();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, W'($urandom));
            n_checks++;
            if ({locked, sel, frame_valid, sync_err} !== 5'b0 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL hunt_noise_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic s;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            // Mostly well-formed framing with occasional misplaced/missing sync.
            s = (m_part.size() == 0) ^ ($urandom_range(0, 11) == 0);
            step($urandom_range(0, 9) < 7, s, W'($urandom));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_missing_sync();
        test_early_sync();
        test_async_reset();
        test_hunt_noise();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
